// File: rtl/lc3_disp_pkg.sv
// lc3_disp_pkg: shared definitions for the LC-3 register display controller.
//   SEL_* : display-select codes driven onto sel (R0-R7, PC, MAR, MDR, IR)
//   seg7  : hex nibble to common-cathode seven-segment pattern {dp,g..a}
package lc3_disp_pkg;

   localparam logic [3:0] SEL_R0   = 4'd0;
   localparam logic [3:0] SEL_R7   = 4'd7;
   localparam logic [3:0] SEL_PC   = 4'd8;
   localparam logic [3:0] SEL_MAR  = 4'd9;
   localparam logic [3:0] SEL_MDR  = 4'd10;
   localparam logic [3:0] SEL_IR   = 4'd11;
   localparam logic [3:0] SEL_LAST = SEL_IR;

   // Decimal point (bit7) is never lit.
   function automatic logic [7:0] seg7(input logic [3:0] hex);
      logic [6:0] g;
      case (hex)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         default: g = 7'h71;
      endcase
      return {1'b0, g};
   endfunction

endpackage

// File: rtl/lc3_debounce.sv
// lc3_debounce: push-button synchronizer, debouncer and press detector.
//   clk, rst  : system clock, async active-low reset
//   btn_raw   : raw asynchronous button (high = pressed)
//   level     : debounced button level
//   press     : 1-clock pulse on each debounced 0->1 transition
module lc3_debounce #(
   parameter logic [19:0] DEB_CNT = 20'd1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   logic [1:0]  sync_q;
   logic [19:0] cnt_q;
   logic        btn_s;

   assign btn_s = sync_q[1];

   // cnt_q counts consecutive clocks on which the synchronized button
   // disagrees with the accepted level; any agreeing sample restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 2'b00;
         cnt_q  <= '0;
         level  <= 1'b0;
         press  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_raw};
         press  <= 1'b0;
         if (btn_s != level) begin
            if (cnt_q == DEB_CNT - 20'd1) begin
               level <= btn_s;
               cnt_q <= '0;
               press <= btn_s;   // only the rising edge pulses
            end else begin
               cnt_q <= cnt_q + 20'd1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/lc3_disp_ctrl.sv
// lc3_disp_ctrl: 4-digit multiplexed hex display of a selectable LC-3 register.
//   clk, rst             : system clock, async active-low reset
//   btn                  : raw push-button; each press steps sel R0..R7,PC,MAR,MDR,IR
//   reg_val              : regfile display port value of R[sel[2:0]]
//   pc, mar, mdr, ir     : architectural register values
//   sel                  : current display select
//   seg                  : seven-segment pattern (common cathode, dp off)
//   an                   : one-hot digit enable, bit0 = least significant digit
module lc3_disp_ctrl #(
   parameter logic [19:0] DEB_CNT  = 20'd1000000,
   parameter logic [11:0] SCAN_DIV = 12'd2500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn,
   input  logic [15:0] reg_val,
   input  logic [15:0] pc,
   input  logic [15:0] mar,
   input  logic [15:0] mdr,
   input  logic [15:0] ir,
   output logic [3:0]  sel,
   output logic [7:0]  seg,
   output logic [3:0]  an
);
   import lc3_disp_pkg::*;

   logic        btn_level;
   logic        press;
   logic        sel_chg_q;
   logic        first_q;
   logic [15:0] src;
   logic [15:0] snap;
   logic [11:0] scan_cnt;
   logic [1:0]  dig;
   logic        scan_tc;
   logic        snap_ld;
   logic [3:0]  nib;

   lc3_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn),
      .level   (btn_level),
      .press   (press)
   );

   // Select register; a press always coincides with a high debounced level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel       <= SEL_R0;
         sel_chg_q <= 1'b0;
      end else begin
         sel_chg_q <= press & btn_level;
         if (press & btn_level)
            sel <= (sel == SEL_LAST) ? SEL_R0 : sel + 4'd1;
      end
   end

   always_comb begin
      src = 16'h0000;
      if (sel <= SEL_R7) begin
         src = reg_val;
      end else begin
         case (sel)
            SEL_PC:  src = pc;
            SEL_MAR: src = mar;
            SEL_MDR: src = mdr;
            SEL_IR:  src = ir;
            default: src = 16'h0000;
         endcase
      end
   end

   assign scan_tc = (scan_cnt == SCAN_DIV - 12'd1);

   // Snapshot refreshes only at scan boundaries so all digits of one scan
   // agree; a sel change reloads one clock later (the load in flight on the
   // press clock still sees the old sel) without disturbing scan position.
   assign snap_ld = first_q | sel_chg_q | (scan_tc & (dig == 2'd3));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first_q  <= 1'b1;
         scan_cnt <= '0;
         dig      <= 2'd0;
         snap     <= 16'h0000;
      end else begin
         first_q <= 1'b0;
         if (scan_tc) begin
            scan_cnt <= '0;
            dig      <= dig + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + 12'd1;
         end
         if (snap_ld)
            snap <= src;
      end
   end

   assign nib = snap[{dig, 2'b00} +: 4];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 4'b0000;
         seg <= 8'h00;
      end else begin
         an  <= 4'b0001 << dig;
         seg <= seg7(nib);
      end
   end

endmodule
